// File: rtl/fsic_coreclk_phase_tracker.sv
// Tracks the ioclk phase within the slower coreclk period from a toggling coreclk marker.
// Optional saturating loss-of-lock counter on err_cnt when FSIC_PHASE_ERR_CNT_EN is defined.
module fsic_coreclk_phase_tracker #(
  parameter int pCLK_RATIO   = 4,
  parameter int pLOCK_CNT    = 4,
  parameter int pSYNC_STAGES = 2,
  parameter int pERR_CNT_W   = 8
) (
  input  logic                          ioclk,
  input  logic                          axis_rst_n,
  input  logic                          core_clk_toggle,
  output logic [$clog2(pCLK_RATIO)-1:0] phase_cnt_out,
  output logic                          phase_locked,
`ifdef FSIC_PHASE_ERR_CNT_EN
  output logic [pERR_CNT_W-1:0]         err_cnt,
`endif
  output logic                          phase_err
);

  localparam int PW = $clog2(pCLK_RATIO);
  localparam int GW = $clog2(pLOCK_CNT + 1);
  localparam logic [PW-1:0] LAST_PHASE  = PW'(pCLK_RATIO - 1);
  localparam logic [GW-1:0] LOCK_TARGET = GW'(pLOCK_CNT);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  logic [pSYNC_STAGES-1:0] r_sync;
  logic                    r_hist;
  state_t                  r_state;
  logic [PW-1:0]           r_phase;
  logic [GW-1:0]           r_good;
  logic                    r_locked;
  logic                    r_err;

  logic          w_edge;
  logic          w_at_last;
  logic          w_good;
  logic          w_bad;
  logic          w_missing;
  logic          w_err_set;
  logic [PW-1:0] w_phase_inc;
  logic [GW-1:0] w_good_inc;

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[pSYNC_STAGES-2:0], core_clk_toggle};
      r_hist <= r_sync[pSYNC_STAGES-1];
    end
  end

  // Edge classification is only meaningful relative to the last phase slot.
  assign w_edge      = r_sync[pSYNC_STAGES-1] ^ r_hist;
  assign w_at_last   = (r_phase == LAST_PHASE);
  assign w_good      = w_edge & w_at_last;
  assign w_bad       = w_edge & ~w_at_last;
  assign w_missing   = ~w_edge & w_at_last;
  assign w_err_set   = (r_state == LOCKED) & (w_bad | w_missing);
  assign w_phase_inc = w_at_last ? '0 : r_phase + 1'b1;
  assign w_good_inc  = r_good + 1'b1;

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state  <= SEARCH;
      r_phase  <= '0;
      r_good   <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err_set;
      case (r_state)
        SEARCH: begin
          if (w_edge) begin
            r_phase <= '0;
            r_good  <= '0;
            r_state <= ACQUIRE;
          end else begin
            r_phase <= w_phase_inc;
          end
        end
        ACQUIRE: begin
          if (w_good) begin
            r_phase <= '0;
            r_good  <= w_good_inc;
            if (w_good_inc == LOCK_TARGET) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
            end
          end else if (w_bad) begin
            r_phase <= '0;
            r_good  <= '0;
          end else if (w_missing) begin
            r_phase <= '0;
            r_good  <= '0;
            r_state <= SEARCH;
          end else begin
            r_phase <= w_phase_inc;
          end
        end
        LOCKED: begin
          if (w_bad) begin
            r_phase  <= '0;
            r_good   <= '0;
            r_state  <= ACQUIRE;
            r_locked <= 1'b0;
          end else if (w_missing) begin
            r_phase  <= '0;
            r_good   <= '0;
            r_state  <= SEARCH;
            r_locked <= 1'b0;
          end else begin
            r_phase <= w_phase_inc;
          end
        end
        default: begin
          r_phase  <= '0;
          r_good   <= '0;
          r_state  <= SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef FSIC_PHASE_ERR_CNT_EN
  logic [pERR_CNT_W-1:0] r_err_cnt;

  always_ff @(posedge ioclk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_err_set && (r_err_cnt != {pERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign phase_cnt_out = r_phase;
  assign phase_locked  = r_locked;
  assign phase_err     = r_err;

endmodule

// File: tb/tb_fsic_coreclk_phase_tracker.sv
// Self-checking bench: three tracker instances (ratio 4/lock 4, ratio 5/lock 4, ratio 2/lock 1)
// compared every cycle against a rule-level model, plus table-driven and hand-written sequences.
module tb_fsic_coreclk_phase_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tog [3];

  logic [1:0] phase_a;
  logic [2:0] phase_b;
  logic [0:0] phase_c;
  logic       lock_a, lock_b, lock_c;
  logic       err_a, err_b, err_c;
`ifdef FSIC_PHASE_ERR_CNT_EN
  logic [7:0] ecnt_a, ecnt_b, ecnt_c;
`endif

  always #5 clk = ~clk;

  fsic_coreclk_phase_tracker #(.pCLK_RATIO(4), .pLOCK_CNT(4), .pSYNC_STAGES(2), .pERR_CNT_W(8)) dut_a (
    .ioclk(clk), .axis_rst_n(rst_n), .core_clk_toggle(tog[0]),
    .phase_cnt_out(phase_a), .phase_locked(lock_a),
`ifdef FSIC_PHASE_ERR_CNT_EN
    .err_cnt(ecnt_a),
`endif
    .phase_err(err_a));

  fsic_coreclk_phase_tracker #(.pCLK_RATIO(5), .pLOCK_CNT(4), .pSYNC_STAGES(2), .pERR_CNT_W(8)) dut_b (
    .ioclk(clk), .axis_rst_n(rst_n), .core_clk_toggle(tog[1]),
    .phase_cnt_out(phase_b), .phase_locked(lock_b),
`ifdef FSIC_PHASE_ERR_CNT_EN
    .err_cnt(ecnt_b),
`endif
    .phase_err(err_b));

  fsic_coreclk_phase_tracker #(.pCLK_RATIO(2), .pLOCK_CNT(1), .pSYNC_STAGES(2), .pERR_CNT_W(8)) dut_c (
    .ioclk(clk), .axis_rst_n(rst_n), .core_clk_toggle(tog[2]),
    .phase_cnt_out(phase_c), .phase_locked(lock_c),
`ifdef FSIC_PHASE_ERR_CNT_EN
    .err_cnt(ecnt_c),
`endif
    .phase_err(err_c));

  int ph_o [3];
  int lk_o [3];
  int er_o [3];
  always_comb begin
    ph_o[0] = int'(phase_a); ph_o[1] = int'(phase_b); ph_o[2] = int'(phase_c);
    lk_o[0] = int'(lock_a);  lk_o[1] = int'(lock_b);  lk_o[2] = int'(lock_c);
    er_o[0] = int'(err_a);   er_o[1] = int'(err_b);   er_o[2] = int'(err_c);
  end

  // Reference model: states 0=search, 1=acquire, 2=locked
  int Rs [3] = '{4, 5, 2};
  int Ls [3] = '{4, 4, 1};
  int ms [3];
  int mp [3];
  int mg [3];
  int merr [3];
  int mcount [3];
  logic [7:0] th [3];

  int n_checks = 0;
  int n_errors = 0;
  int g [3];
  int cnt [3];
  int mode = 0;
  int flips_a = 0;
  int seen_err_a = 0;

  typedef struct {
    int gap;
    int lk;
    int ph;
    int errs;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      ms[d] = 0; mp[d] = 0; mg[d] = 0; merr[d] = 0; mcount[d] = 0; th[d] = '0;
    end
  endtask

  task automatic model_step(input int d, input bit e);
    bit last;
    last = (mp[d] == Rs[d] - 1);
    merr[d] = 0;
    // Any edge realigns to phase 0; otherwise the phase advances modulo the ratio.
    mp[d] = e ? 0 : (mp[d] + 1) % Rs[d];
    if (ms[d] == 0) begin
      if (e) begin ms[d] = 1; mg[d] = 0; end
    end else if (ms[d] == 1) begin
      if (e && last) begin
        mg[d]++;
        if (mg[d] == Ls[d]) ms[d] = 2;
      end else if (e) begin
        mg[d] = 0;
      end else if (last) begin
        mg[d] = 0; ms[d] = 0;
      end
    end else begin
      if (e && !last) begin
        mg[d] = 0; ms[d] = 1; merr[d] = 1;
      end else if (!e && last) begin
        mg[d] = 0; ms[d] = 0; merr[d] = 1;
      end
    end
    if (merr[d] != 0) mcount[d]++;
  endtask

  task automatic tick();
    bit e;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      th[d] = {th[d][6:0], tog[d]};
      e = th[d][2] ^ th[d][3];
      model_step(d, e);
      chk($sformatf("d%0d_phase", d), ph_o[d], mp[d]);
      chk($sformatf("d%0d_locked", d), lk_o[d], (ms[d] == 2) ? 1 : 0);
      chk($sformatf("d%0d_err", d), er_o[d], merr[d]);
    end
`ifdef FSIC_PHASE_ERR_CNT_EN
    chk("a_err_cnt", int'(ecnt_a), (mcount[0] > 255) ? 255 : mcount[0]);
    chk("b_err_cnt", int'(ecnt_b), (mcount[1] > 255) ? 255 : mcount[1]);
    chk("c_err_cnt", int'(ecnt_c), (mcount[2] > 255) ? 255 : mcount[2]);
`endif
    chk("b_phase_range", (ph_o[1] < 5) ? 1 : 0, 1);
    if (err_a) seen_err_a++;
    @(negedge clk);
  endtask

  function automatic int pick_rand(input int d);
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return (Rs[d] > 1) ? Rs[d] - 1 : 1;
    if (r == 1) return Rs[d] + 1;
    if (r == 2) return 3 * Rs[d];
    return Rs[d];
  endfunction

  task automatic drive();
    for (int d = 0; d < 3; d++) begin
      if (g[d] != 0) begin
        if (cnt[d] == 0) begin
          tog[d] = ~tog[d];
          if (d == 0) flips_a++;
          if (mode == 1) g[d] = pick_rand(d);
          else if (mode == 2 && d == 0) g[0] = (flips_a % 5 == 0) ? 3 : 4;
          cnt[d] = g[d];
        end
        cnt[d]--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      tick();
    end
  endtask

  // Called at a falling edge; the reset lands mid-cycle to observe its asynchronous effect.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_phase", ph_o[0] + ph_o[1] + ph_o[2], 0);
    chk("rst_locked", lk_o[0] + lk_o[1] + lk_o[2], 0);
    chk("rst_err", er_o[0] + er_o[1] + er_o[2], 0);
`ifdef FSIC_PHASE_ERR_CNT_EN
    chk("rst_err_cnt", int'(ecnt_a) + int'(ecnt_b) + int'(ecnt_c), 0);
`endif
    model_reset();
    for (int d = 0; d < 3; d++) begin
      tog[d] = 1'b0;
      cnt[d] = 0;
    end
    flips_a = 0;
    seen_err_a = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 4; i++)  tbl[i] = '{4, 0, 1, 0};
    tbl[4]  = '{4, 1, 1, 0};
    tbl[5]  = '{4, 1, 1, 0};
    tbl[6]  = '{5, 1, 2, 0};
    for (int i = 7; i < 11; i++) tbl[i] = '{4, 0, 1, 1};
    tbl[11] = '{4, 1, 1, 1};
    tbl[12] = '{3, 1, 0, 1};
    for (int i = 13; i < 17; i++) tbl[i] = '{4, 0, 1, 2};
    tbl[17] = '{4, 1, 1, 2};
    tbl[18] = '{20, 0, 1, 3};

    for (int d = 0; d < 3; d++) begin
      tog[d] = 1'b0; g[d] = 0; cnt[d] = 0;
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Ratio 4: lock, late toggle, early toggle, then toggle stops
    for (int i = 0; i < 19; i++) begin
      g[0] = tbl[i].gap;
      run(tbl[i].gap);
      chk($sformatf("tbl%0d_locked", i), int'(lock_a), tbl[i].lk);
      chk($sformatf("tbl%0d_phase", i), int'(phase_a), tbl[i].ph);
      chk($sformatf("tbl%0d_errs", i), seen_err_a, tbl[i].errs);
      $display("row %0d gap=%0d locked=%0d phase=%0d errs=%0d", i, tbl[i].gap, lock_a, phase_a, seen_err_a);
    end

    // Ratio 2, lock count 1: lock right after the first good edge
    do_reset();
    g[0] = 0; g[1] = 0; g[2] = 2;
    run(4);
    chk("c_lock_before_good", int'(lock_c), 0);
    chk("c_phase_t3", int'(phase_c), 1);
    run(1);
    chk("c_lock_after_good", int'(lock_c), 1);
    chk("c_phase_t4", int'(phase_c), 0);
    run(1);
    chk("c_phase_t5", int'(phase_c), 1);

    // Ratio 4 and ratio 5 steady toggling
    g[0] = 4; g[1] = 5;
    run(60);
    chk("a_steady_locked", int'(lock_a), 1);
    chk("b_steady_locked", int'(lock_b), 1);
    chk("c_steady_locked", int'(lock_c), 1);
    $display("steady: lock_a=%0d lock_b=%0d lock_c=%0d", lock_a, lock_b, lock_c);

    // Reset mid-lock, then a full relock sequence is needed
    do_reset();
    run(18);
    chk("a_relock_early", int'(lock_a), 0);
    run(1);
    chk("a_relock", int'(lock_a), 1);
    $display("relock after reset: lock_a=%0d", lock_a);

    // Randomized jitter and stalls
    mode = 1;
    run(3000);
    $display("random: model errs a=%0d b=%0d c=%0d", mcount[0], mcount[1], mcount[2]);

    // Repeated induced errors on ratio 4 to reach counter saturation
    do_reset();
    mode = 2; g[0] = 4; g[1] = 0; g[2] = 0;
    guard = 0;
    while (mcount[0] < 300 && guard < 8000) begin
      run(1);
      guard++;
    end
    chk("sat_within_budget", (guard < 8000) ? 1 : 0, 1);
    run(20);
    chk("a_err_pulses", seen_err_a, mcount[0]);
`ifdef FSIC_PHASE_ERR_CNT_EN
    chk("a_err_cnt_sat", int'(ecnt_a), 255);
`endif
    $display("saturation: errs=%0d cycles=%0d", mcount[0], guard);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
